// File: rtl/hazard_pkg.sv
// Shared state encoding, parameter defaults and sizing helper for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned HZ_REG_ADDR_W      = 5;
  localparam int unsigned HZ_LOAD_USE_STALLS = 1;
  localparam int unsigned HZ_MC_LATENCY      = 4;
  localparam int unsigned HZ_CNT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MC_BUSY    = 2'd2
  } hz_state_e;

  // Width of the sequencing down-counter: clog2(max(lus, mcl)), never below one bit.
  function automatic int unsigned hz_down_cnt_w(input int unsigned lus, input int unsigned mcl);
    int unsigned m;
    m = (lus > mcl) ? lus : mcl;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side view of the hazard controller: ID/EX status in, stall/flush controls out.
interface hazard_ctrl_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = HZ_REG_ADDR_W,
  parameter int unsigned CNT_W      = HZ_CNT_W
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_mc_start;
  logic                  ex_redirect;

  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  ex_hold;
  logic                  ex_mem_bubble;
  logic                  mc_done;
  logic                  busy;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_rd, ex_mem_read, ex_mc_start, ex_redirect,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
           ex_hold, ex_mem_bubble, mc_done, busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_rd, ex_mem_read, ex_mc_start, ex_redirect,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
           ex_hold, ex_mem_bubble, mc_done, busy, stall_cnt
  );
endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle EX sequencing and EX redirect squash.
// Control outputs are combinational from state and inputs so they act in the same cycle.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W      = HZ_REG_ADDR_W,
  parameter int unsigned LOAD_USE_STALLS = HZ_LOAD_USE_STALLS,
  parameter int unsigned MC_LATENCY      = HZ_MC_LATENCY,
  parameter int unsigned CNT_W           = HZ_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  hazard_ctrl_unit_if.slave  hz
);
  localparam int unsigned CW = hz_down_cnt_w(LOAD_USE_STALLS, MC_LATENCY);
  localparam logic [CW-1:0] MC_INIT = CW'(MC_LATENCY - 2);
  localparam logic [CW-1:0] LU_INIT = CW'((LOAD_USE_STALLS > 1) ? (LOAD_USE_STALLS - 2) : 0);

  if (LOAD_USE_STALLS < 1 || MC_LATENCY < 2) begin : g_param_check
    $error("hazard_ctrl_unit: LOAD_USE_STALLS must be >= 1 and MC_LATENCY >= 2");
  end

  hz_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lu_hazard_c;

  assign lu_hazard_c = hz.id_valid && hz.ex_valid && hz.ex_mem_read
                    && (hz.ex_rd != REG_ADDR_W'(0))
                    && ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd))
                     || (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and same-cycle controls; redirect outranks multi-cycle start, which outranks load-use.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    hz.pc_stall      = 1'b0;
    hz.if_id_stall   = 1'b0;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_bubble  = 1'b0;
    hz.ex_hold       = 1'b0;
    hz.ex_mem_bubble = 1'b0;
    hz.mc_done       = 1'b0;
    hz.busy          = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (hz.ex_redirect) begin
          hz.if_id_flush  = 1'b1;
          hz.id_ex_bubble = 1'b1;
        end else if (hz.ex_mc_start) begin
          hz.ex_hold       = 1'b1;
          hz.pc_stall      = 1'b1;
          hz.if_id_stall   = 1'b1;
          hz.ex_mem_bubble = 1'b1;
          state_d          = ST_MC_BUSY;
          cnt_d            = MC_INIT;
        end else if (lu_hazard_c) begin
          hz.pc_stall     = 1'b1;
          hz.if_id_stall  = 1'b1;
          hz.id_ex_bubble = 1'b1;
          if (LOAD_USE_STALLS > 1) begin
            state_d = ST_LOAD_STALL;
            cnt_d   = LU_INIT;
          end
        end
      end
      ST_LOAD_STALL: begin
        if (hz.ex_redirect) begin
          hz.if_id_flush  = 1'b1;
          hz.id_ex_bubble = 1'b1;
          state_d         = ST_IDLE;
          cnt_d           = '0;
        end else begin
          hz.pc_stall     = 1'b1;
          hz.if_id_stall  = 1'b1;
          hz.id_ex_bubble = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_MC_BUSY: begin
        if (cnt_q == '0) begin
          hz.mc_done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          hz.ex_hold       = 1'b1;
          hz.pc_stall      = 1'b1;
          hz.if_id_stall   = 1'b1;
          hz.ex_mem_bubble = 1'b1;
          cnt_d            = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (hz.pc_stall),
    .cnt (hz.stall_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two parameterisations driven in lockstep, checked against a cycle-level reference.
module tb_hazard_ctrl_unit;
  localparam int unsigned MC_A  = 4;
  localparam int unsigned MC_B  = 3;
  localparam int          MAX_A = 65535;
  localparam int          MAX_B = 15;

  // o bits: 7 pc_stall, 6 if_id_stall, 5 if_id_flush, 4 id_ex_bubble, 3 ex_hold, 2 ex_mem_bubble, 1 mc_done, 0 busy
  typedef struct packed {
    logic [7:0] o;
    int         n_lu;
    int         n_mc;
  } mres_t;

  logic       clk, rst;
  logic       id_valid, rs1_used, rs2_used, ex_valid, ex_mem_read, ex_mc_start, ex_redirect;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  int total = 0;
  int bad   = 0;

  hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) if_a ();
  hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(4))  if_b ();

  assign if_a.id_valid = id_valid;      assign if_b.id_valid = id_valid;
  assign if_a.id_rs1 = id_rs1;          assign if_b.id_rs1 = id_rs1;
  assign if_a.id_rs2 = id_rs2;          assign if_b.id_rs2 = id_rs2;
  assign if_a.id_rs1_used = rs1_used;   assign if_b.id_rs1_used = rs1_used;
  assign if_a.id_rs2_used = rs2_used;   assign if_b.id_rs2_used = rs2_used;
  assign if_a.ex_valid = ex_valid;      assign if_b.ex_valid = ex_valid;
  assign if_a.ex_rd = ex_rd;            assign if_b.ex_rd = ex_rd;
  assign if_a.ex_mem_read = ex_mem_read; assign if_b.ex_mem_read = ex_mem_read;
  assign if_a.ex_mc_start = ex_mc_start; assign if_b.ex_mc_start = ex_mc_start;
  assign if_a.ex_redirect = ex_redirect; assign if_b.ex_redirect = ex_redirect;

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .MC_LATENCY(MC_A), .CNT_W(16)) dut_a (
    .clk (clk), .rst (rst), .hz (if_a.slave)
  );
  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .MC_LATENCY(MC_B), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .hz (if_b.slave)
  );

  logic [7:0] obs_a, obs_b;
  assign obs_a = {if_a.pc_stall, if_a.if_id_stall, if_a.if_id_flush, if_a.id_ex_bubble,
                  if_a.ex_hold, if_a.ex_mem_bubble, if_a.mc_done, if_a.busy};
  assign obs_b = {if_b.pc_stall, if_b.if_id_stall, if_b.if_id_flush, if_b.id_ex_bubble,
                  if_b.ex_hold, if_b.ex_mem_bubble, if_b.mc_done, if_b.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lu_left = bubbles still owed, mc_k = 1-based EX cycle index of a running multi-cycle op (0 = none).
  function automatic mres_t mstep(input int lus, input int mcl, input int lu_left, input int mc_k,
                                  input logic haz, input logic redir, input logic mcs);
    mres_t r;
    r.o = '0; r.n_lu = lu_left; r.n_mc = mc_k;
    if (mc_k != 0) begin
      r.o[0] = 1'b1;
      if (mc_k < mcl) begin r.o[7] = 1; r.o[6] = 1; r.o[3] = 1; r.o[2] = 1; r.n_mc = mc_k + 1; end
      else begin r.o[1] = 1; r.n_mc = 0; end
    end else if (lu_left != 0) begin
      r.o[0] = 1'b1;
      if (redir) begin r.o[5] = 1; r.o[4] = 1; r.n_lu = 0; end
      else begin r.o[7] = 1; r.o[6] = 1; r.o[4] = 1; r.n_lu = lu_left - 1; end
    end else if (redir) begin
      r.o[5] = 1; r.o[4] = 1;
    end else if (mcs) begin
      r.o[7] = 1; r.o[6] = 1; r.o[3] = 1; r.o[2] = 1; r.n_mc = 2;
    end else if (haz) begin
      r.o[7] = 1; r.o[6] = 1; r.o[4] = 1; r.n_lu = lus - 1;
    end
    return r;
  endfunction

  logic  haz;
  int    lu_a = 0, mc_a = 0, sc_a = 0, lu_b = 0, mc_b = 0, sc_b = 0;
  mres_t res_a, res_b;
  logic [7:0] exp_a, exp_b;

  always_comb begin
    haz = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
       && ((rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd)));
    res_a = mstep(1, MC_A, lu_a, mc_a, haz, ex_redirect, ex_mc_start);
    res_b = mstep(2, MC_B, lu_b, mc_b, haz, ex_redirect, ex_mc_start);
    exp_a = res_a.o;
    exp_b = res_b.o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_a <= 0; mc_a <= 0; sc_a <= 0; lu_b <= 0; mc_b <= 0; sc_b <= 0;
    end else begin
      lu_a <= res_a.n_lu; mc_a <= res_a.n_mc;
      lu_b <= res_b.n_lu; mc_b <= res_b.n_mc;
      if (res_a.o[7] && sc_a < MAX_A) sc_a <= sc_a + 1;
      if (res_b.o[7] && sc_b < MAX_B) sc_b <= sc_b + 1;
    end
  end

  task automatic quiet();
    id_valid = 0; rs1_used = 0; rs2_used = 0; ex_valid = 0; ex_mem_read = 0;
    ex_mc_start = 0; ex_redirect = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
  endtask

  task automatic set_haz();
    id_valid = 1; ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd5;
    id_rs2 = 5'd5; rs2_used = 1; id_rs1 = 5'd0; rs1_used = 1;
  endtask

  task automatic do_reset();
    quiet(); rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    quiet(); rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    total++; if (obs_a !== 8'h00 || if_a.stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_a got=%b/%0d want=00000000/0", obs_a, if_a.stall_cnt); end
    total++; if (obs_b !== 8'h00 || if_b.stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_b got=%b/%0d want=00000000/0", obs_b, if_b.stall_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      quiet(); if (c == 0) set_haz();
      @(negedge clk);
      total++; if (obs_a !== exp_a || int'(if_a.stall_cnt) !== sc_a) begin bad++; $display("FAIL load_use_a cyc=%0d got=%b/%0d want=%b/%0d", c, obs_a, if_a.stall_cnt, exp_a, sc_a); end
      total++; if (obs_b !== exp_b || int'(if_b.stall_cnt) !== sc_b) begin bad++; $display("FAIL load_use_b cyc=%0d got=%b/%0d want=%b/%0d", c, obs_b, if_b.stall_cnt, exp_b, sc_b); end
      total++; if ({if_a.pc_stall, if_a.id_ex_bubble, if_a.busy} !== {c == 0, c == 0, 1'b0}) begin bad++; $display("FAIL lu1_seq cyc=%0d got=%b want pc/bub=%0d busy=0", c, {if_a.pc_stall, if_a.id_ex_bubble, if_a.busy}, c == 0); end
      total++; if ({if_b.pc_stall, if_b.id_ex_bubble, if_b.busy} !== {c < 2, c < 2, c == 1}) begin bad++; $display("FAIL lu2_seq cyc=%0d got=%b want=%b", c, {if_b.pc_stall, if_b.id_ex_bubble, if_b.busy}, {c < 2, c < 2, c == 1}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_false_hazard();
    for (int c = 0; c < 3; c++) begin
      set_haz();
      if (c == 0) begin ex_rd = 5'd0; id_rs2 = 5'd0; end
      if (c == 1) begin id_rs1 = 5'd5; rs1_used = 0; id_rs2 = 5'd7; end
      if (c == 2) ex_valid = 0;
      @(negedge clk);
      total++; if (if_a.pc_stall !== 1'b0 || if_b.pc_stall !== 1'b0 || if_b.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL false_haz pat=%0d got a=%b b=%b want no stall", c, if_a.pc_stall, if_b.pc_stall); end
      total++; if (obs_b !== exp_b) begin bad++; $display("FAIL false_haz_b pat=%0d got=%b want=%b", c, obs_b, exp_b); end
      @(posedge clk); #1;
    end
    quiet();
  endtask

  task automatic test_multicycle();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      quiet(); ex_mc_start = (c == 0);
      @(negedge clk);
      total++; if (obs_a !== exp_a || int'(if_a.stall_cnt) !== sc_a) begin bad++; $display("FAIL mc_a cyc=%0d got=%b/%0d want=%b/%0d", c, obs_a, if_a.stall_cnt, exp_a, sc_a); end
      total++; if (obs_b !== exp_b || int'(if_b.stall_cnt) !== sc_b) begin bad++; $display("FAIL mc_b cyc=%0d got=%b/%0d want=%b/%0d", c, obs_b, if_b.stall_cnt, exp_b, sc_b); end
      total++; if ({if_a.ex_hold, if_a.pc_stall, if_a.mc_done} !== {c < 3, c < 3, c == 3}) begin bad++; $display("FAIL mc4_seq cyc=%0d got=%b want=%b", c, {if_a.ex_hold, if_a.pc_stall, if_a.mc_done}, {c < 3, c < 3, c == 3}); end
      total++; if ({if_b.ex_hold, if_b.mc_done} !== {c < 2, c == 2}) begin bad++; $display("FAIL mc3_seq cyc=%0d got=%b want=%b", c, {if_b.ex_hold, if_b.mc_done}, {c < 2, c == 2}); end
      @(posedge clk); #1;
    end
    total++; if (if_a.stall_cnt !== 16'd3 || if_b.stall_cnt !== 4'd2) begin bad++; $display("FAIL mc_stall_cnt got a=%0d b=%0d want a=3 b=2", if_a.stall_cnt, if_b.stall_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      quiet();
      if (c == 0) begin set_haz(); ex_redirect = 1; end
      if (c == 2) set_haz();
      if (c == 3) ex_redirect = 1;
      @(negedge clk);
      total++; if (obs_a !== exp_a) begin bad++; $display("FAIL redir_a cyc=%0d got=%b want=%b", c, obs_a, exp_a); end
      total++; if (obs_b !== exp_b) begin bad++; $display("FAIL redir_b cyc=%0d got=%b want=%b", c, obs_b, exp_b); end
      if (c == 0) begin
        total++; if ({if_a.if_id_flush, if_a.id_ex_bubble, if_a.pc_stall} !== 3'b110) begin bad++; $display("FAIL redir_idle got=%b want=110", {if_a.if_id_flush, if_a.id_ex_bubble, if_a.pc_stall}); end
      end
      if (c == 3) begin
        total++; if ({if_b.if_id_flush, if_b.id_ex_bubble, if_b.pc_stall, if_b.busy} !== 4'b1101) begin bad++; $display("FAIL redir_lstall got=%b want=1101", {if_b.if_id_flush, if_b.id_ex_bubble, if_b.pc_stall, if_b.busy}); end
      end
      if (c == 4) begin
        total++; if (if_b.busy !== 1'b0) begin bad++; $display("FAIL redir_idle_next got busy=%b want=0", if_b.busy); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      quiet();
      if (c < 5) set_haz();
      ex_mc_start = (c == 0);
      ex_redirect = (c == 1);
      @(negedge clk);
      total++; if (obs_a !== exp_a) begin bad++; $display("FAIL prio_a cyc=%0d got=%b want=%b", c, obs_a, exp_a); end
      total++; if (obs_b !== exp_b) begin bad++; $display("FAIL prio_b cyc=%0d got=%b want=%b", c, obs_b, exp_b); end
      total++; if ({if_a.ex_hold, if_a.id_ex_bubble, if_a.if_id_flush, if_a.mc_done} !== {c < 3, c == 4, 1'b0, c == 3}) begin bad++; $display("FAIL prio_seq cyc=%0d got=%b want=%b", c, {if_a.ex_hold, if_a.id_ex_bubble, if_a.if_id_flush, if_a.mc_done}, {c < 3, c == 4, 1'b0, c == 3}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      quiet();
      ex_mc_start = (c == 0);
      rst = (c == 2);
      @(negedge clk);
      total++; if (obs_a !== exp_a || int'(if_a.stall_cnt) !== sc_a) begin bad++; $display("FAIL rst_mid_a cyc=%0d got=%b/%0d want=%b/%0d", c, obs_a, if_a.stall_cnt, exp_a, sc_a); end
      total++; if (obs_b !== exp_b || int'(if_b.stall_cnt) !== sc_b) begin bad++; $display("FAIL rst_mid_b cyc=%0d got=%b/%0d want=%b/%0d", c, obs_b, if_b.stall_cnt, exp_b, sc_b); end
      if (c == 3) begin
        total++; if ({if_a.mc_done, if_a.busy} !== 2'b00 || if_a.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_abandon got done/busy=%b cnt=%0d want 00/0", {if_a.mc_done, if_a.busy}, if_a.stall_cnt); end
      end
      @(posedge clk); #1;
    end
    rst = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_haz();
      @(negedge clk);
      total++; if (obs_b !== exp_b || int'(if_b.stall_cnt) !== sc_b) begin bad++; $display("FAIL sat_b cyc=%0d got=%b/%0d want=%b/%0d", c, obs_b, if_b.stall_cnt, exp_b, sc_b); end
      @(posedge clk); #1;
    end
    quiet();
    @(negedge clk);
    total++; if (if_a.stall_cnt !== 16'd20 || if_b.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_final got a=%0d b=%0d want a=20 b=15", if_a.stall_cnt, if_b.stall_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 49) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_mem_read = $urandom_range(0, 1) != 0;
      rs1_used    = $urandom_range(0, 1) != 0;
      rs2_used    = $urandom_range(0, 1) != 0;
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_mc_start = ($urandom_range(0, 9) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      total++; if (obs_a !== exp_a || int'(if_a.stall_cnt) !== sc_a) begin bad++; $display("FAIL rand_a cyc=%0d got=%b/%0d want=%b/%0d", c, obs_a, if_a.stall_cnt, exp_a, sc_a); end
      total++; if (obs_b !== exp_b || int'(if_b.stall_cnt) !== sc_b) begin bad++; $display("FAIL rand_b cyc=%0d got=%b/%0d want=%b/%0d", c, obs_b, if_b.stall_cnt, exp_b, sc_b); end
      @(posedge clk); #1;
    end
    rst = 0;
    quiet();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_false_hazard();
    test_multicycle();
    test_redirect();
    test_priority();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage RISC-V core. It supersedes the single-cycle ID_EXBubble input to ControlUnit with a sequenced stall/flush engine. It detects load-use hazards, sequences configurable-length multi-cycle EX operations (MUL/DIV), and squashes younger stages on a redirect resolved in EX. Its outputs drive the PC, IF/ID and ID/EX registers and ControlUnit.ID_EXBubble.

Parameters:
REG_ADDR_W, 5, register index width
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (>=1; 2 when no MEM->EX forwarding)
MC_LATENCY, 4, total EX cycles of a multi-cycle op (>=2)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  valid instruction in ID
id_rs1  in  REG_ADDR_W  ID source 1
id_rs2  in  REG_ADDR_W  ID source 2
id_rs1_used  in  1  ID reads rs1
id_rs2_used  in  1  ID reads rs2
ex_valid  in  1  valid instruction in EX
ex_rd  in  REG_ADDR_W  EX destination
ex_mem_read  in  1  EX instruction is a load
ex_mc_start  in  1  multi-cycle op enters EX this cycle
ex_redirect  in  1  taken branch/JAL/JALR resolved in EX
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to NOP
id_ex_bubble  out  1  to ControlUnit.ID_EXBubble (zero control into ID/EX)
ex_hold  out  1  hold ID/EX and EX operands
ex_mem_bubble  out  1  insert NOP into EX/MEM
mc_done  out  1  one-cycle pulse, last cycle of multi-cycle op
busy  out  1  FSM not in IDLE
stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Synchronous clk and rst are fixed: one clock, synchronous active-high reset.
- Reset: FSM=IDLE, internal down-counter=0, stall_cnt=0. All control outputs are combinational from state/inputs and evaluate to 0 in IDLE with quiet inputs.
- The rst=1 mid-sequence sets IDLE on the next edge. The in-progress stall/MC sequence is abandoned and no mc_done is produced.
- lu_hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- FSM states: IDLE, LOAD_STALL, MC_BUSY.
- IDLE, decision priority:
  - ex_redirect first: assert if_id_flush=1 and id_ex_bubble=1 in the same cycle. Stay IDLE. Any lu_hazard is ignored because the ID instruction is squashed.
  - ex_mc_start next: go to MC_BUSY with cnt=MC_LATENCY-2. In this first cycle, ex_hold=pc_stall=if_id_stall=ex_mem_bubble=1.
  - lu_hazard next: assert pc_stall=if_id_stall=id_ex_bubble=1 in the same cycle. If LOAD_USE_STALLS>1, go to LOAD_STALL with cnt=LOAD_USE_STALLS-2.
  - If both lu_hazard and ex_mc_start are set, ex_mc_start wins. The hazard re-evaluates after MC_BUSY, since the ID instruction is still held.
- LOAD_STALL: assert pc_stall=if_id_stall=id_ex_bubble=1.
  - cnt==0: go to IDLE, else decrement.
  - ex_redirect: assert flush+bubble and go to IDLE immediately. Stall outputs are 0 that cycle.
- MC_BUSY: assert ex_hold=pc_stall=if_id_stall=ex_mem_bubble=1, id_ex_bubble=0.
  - cnt==0: assert mc_done=1, drop ex_hold and ex_mem_bubble (result leaves EX), go to IDLE; pc_stall is 0 that cycle.
  - Otherwise decrement.
  - ex_redirect and ex_mc_start are ignored in MC_BUSY.
- Total EX occupancy of a multi-cycle op is exactly MC_LATENCY cycles, start cycle included.
- Total bubbles per load-use hazard is exactly LOAD_USE_STALLS.
- stall_cnt increments on each cycle with pc_stall=1 and saturates at all-ones; it does not wrap.
- busy = (state!=IDLE).
- Elaboration check: LOAD_USE_STALLS<1 or MC_LATENCY<2 is an error.

Decomposition:
- hazard_pkg holds the FSM state encoding (IDLE=2'd0, LOAD_STALL=2'd1, MC_BUSY=2'd2), parameter defaults, and the counter width function clog2(max(LOAD_USE_STALLS, MC_LATENCY)).
- One sub-module: hazard_sat_counter (CNT_W saturating incrementer with sync clear), used for stall_cnt.
- The down-counter stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1, LOAD_USE_STALLS=1 -> exactly 1 cycle with pc_stall=id_ex_bubble=1; busy stays 0. With LOAD_USE_STALLS=2 -> 2 cycles, busy=1 on the second.
- False hazards: ex_rd=0, or id_rs1_used=0 with id_rs1 matching, or ex_valid=0 -> no stall.
- Multi-cycle, MC_LATENCY=4: ex_mc_start pulse -> ex_hold=1 for 3 cycles, mc_done on the 4th, pc_stall high for 3 cycles, stall_cnt=3.
- Redirect: redirect in IDLE with lu_hazard=1 -> flush+bubble for 1 cycle, pc_stall=0. Redirect in the 2nd LOAD_STALL cycle -> flush, IDLE next cycle.
- Priority and ignore: simultaneous ex_mc_start and lu_hazard -> MC_BUSY first, then 1 load bubble. Redirect during MC_BUSY -> no flush.
- Reset and saturation: rst=1 in MC_BUSY cnt=1 -> IDLE with no mc_done. CNT_W=4 with 20 stall cycles -> stall_cnt=15.
